inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 89 ++++++++
 tb/tb_inst_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: credit-limited instruction fetch with in-order response tracking,
// a fetch queue feeding decode, and redirect flushing of stale responses.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] new_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [CW:0] DEPTH = (CW + 1)'(FQ_DEPTH);

  logic [31:0] fpc;
  logic [CW-1:0] out_cnt, drop_cnt, q_cnt, out_nxt;
  logic [CW:0] used;
  logic [31:0] q_pc [FQ_DEPTH];
  logic [31:0] q_data [FQ_DEPTH];
  logic [31:0] pf_pc [FQ_DEPTH];
  logic [AW-1:0] q_rd, q_wr, pf_rd, pf_wr;
  logic acc, rsp, drop, push, pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FQ_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign used = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign imem_req_valid = !rst && !branch_taken && (used < DEPTH);
  assign imem_req_addr = fpc;
  assign acc = imem_req_valid && imem_req_ready;
  assign rsp = imem_rsp_valid;
  assign drop = drop_cnt != '0;
  assign push = rsp && !drop && !branch_taken;
  assign inst_valid = q_cnt != '0;
  assign pop = inst_valid && !stall && !branch_taken;
  assign inst = inst_valid ? q_data[q_rd] : 32'h0;
  assign inst_pc = inst_valid ? q_pc[q_rd] : 32'h0;
  // Accounting includes this cycle's accept and response so a redirect drops exactly what is still owed.
  assign out_nxt = out_cnt + CW'(acc) - CW'(rsp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc <= RESET_PC;
      out_cnt <= '0;
      drop_cnt <= '0;
      q_cnt <= '0;
      q_rd <= '0;
      q_wr <= '0;
      pf_rd <= '0;
      pf_wr <= '0;
    end else begin
      out_cnt <= out_nxt;
      if (acc) pf_wr <= nxt(pf_wr);
      if (rsp) pf_rd <= nxt(pf_rd);
      if (branch_taken) begin
        fpc <= {new_pc[31:2], 2'b00};
        drop_cnt <= out_nxt;
        q_cnt <= '0;
        q_rd <= '0;
        q_wr <= '0;
      end else begin
        if (acc) fpc <= fpc + 32'd4;
        if (rsp && drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) q_wr <= nxt(q_wr);
        if (pop) q_rd <= nxt(q_rd);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) pf_pc[pf_wr] <= fpc;
    if (push) begin
      q_pc[q_wr] <= pf_pc[pf_rd];
      q_data[q_wr] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed checks of inst_fetch against an
// epoch-tagged memory/queue reference model.
module tb_inst_fetch;
  localparam int FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk, rst, stall, branch_taken, imem_req_valid, imem_req_ready;
  logic imem_rsp_valid, inst_valid;
  logic [31:0] new_pc, imem_req_addr, imem_rsp_data, inst, inst_pc;

  inst_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .new_pc(new_pc), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  typedef struct {logic [31:0] a; int ep; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
  req_t mq[$];
  ent_t fq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] efpc;
  logic last_rv;
  int epoch = 0, cyc = 0, lat = 1, tests = 0, fails = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h0101_0101;
  endfunction

  // One clock of stimulus; the memory answers in order once a request's latency has elapsed.
  task automatic step(input logic s, input logic b, input logic [31:0] np, input logic r);
    logic rv, ev, a, push, pop;
    req_t h;
    ent_t e;
    stall = s; branch_taken = b; new_pc = np; imem_req_ready = r;
    rv = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? mem(mq[0].a) : $urandom;
    @(negedge clk);
    ev = (mq.size() + fq.size() < FQ_DEPTH) && !b;
    last_rv = imem_req_valid;
    tests++;
    if (imem_req_valid !== ev) begin fails++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, ev); end
    if (ev) begin
      tests++;
      if (imem_req_addr !== efpc) begin fails++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, efpc); end
    end
    tests++;
    if (inst_valid !== (fq.size() > 0)) begin fails++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, fq.size() > 0); end
    e = fq.size() > 0 ? fq[0] : '{32'h0, 32'h0};
    tests++;
    if ({inst_pc, inst} !== {e.pc, e.d}) begin fails++; $display("FAIL inst cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_pc, inst, e.pc, e.d); end
    a = ev && r;
    pop = fq.size() > 0 && !s && !b;
    push = 0;
    if (rv) begin
      h = mq.pop_front();
      push = h.ep == epoch && !b;
    end
    if (pop) pop_log.push_back(fq.pop_front().pc);
    if (push) begin e.pc = h.a; e.d = mem(h.a); fq.push_back(e); end
    if (a) begin
      h.a = efpc; h.ep = epoch; h.due = cyc + lat;
      mq.push_back(h); acc_log.push_back(efpc); efpc += 32'd4;
    end
    if (b) begin fq.delete(); epoch++; efpc = {np[31:2], 2'b00}; end
    tests++;
    if (fq.size() > FQ_DEPTH) begin fails++; $display("FAIL overflow cyc=%0d size=%0d max=%0d", cyc, fq.size(), FQ_DEPTH); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic assert_rst();
    rst = 1; stall = 0; branch_taken = 0; new_pc = 0; imem_rsp_valid = 0; imem_req_ready = 0;
    #1;
    mq.delete(); fq.delete(); epoch++; efpc = RESET_PC;
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst = 0;
    acc_log.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    assert_rst();
    tests++;
    if ({imem_req_valid, inst_valid, inst, inst_pc} !== 66'h0) begin fails++; $display("FAIL reset_outputs got=%b%b %h %h exp=0", imem_req_valid, inst_valid, inst, inst_pc); end
    release_rst();
    lat = 1;
    step(0, 0, 0, 1);
    tests++;
    if (acc_log.size() != 1 || acc_log[0] !== RESET_PC) begin fails++; $display("FAIL reset_first_req got=%0d reqs exp=1 at %h", acc_log.size(), RESET_PC); end
  endtask

  task automatic test_stream();
    assert_rst(); release_rst();
    lat = 1;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (acc_log[i] !== 32'(4 * i)) begin fails++; $display("FAIL stream_req%0d got=%h exp=%h", i, acc_log[i], 4 * i); end
      tests++;
      if (pop_log[i] !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc%0d got=%h exp=%h", i, pop_log[i], 4 * i); end
    end
  endtask

  task automatic test_stall();
    int n;
    assert_rst(); release_rst();
    lat = 1; n = 0;
    while (!(inst_valid === 1'b1 && inst_pc === 32'h4) && n < 20) begin step(0, 0, 0, 1); n++; end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL stall_wait got=timeout exp=inst_pc 4"); end
    pop_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1);
      tests++;
      if (inst_pc !== 32'h4) begin fails++; $display("FAIL stall_hold got=%h exp=00000004", inst_pc); end
    end
    tests++;
    if (last_rv !== 1'b0) begin fails++; $display("FAIL stall_credit got=%b exp=0", last_rv); end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (pop_log[i] !== 32'(4 + 4 * i)) begin fails++; $display("FAIL stall_order%0d got=%h exp=%h", i, pop_log[i], 4 + 4 * i); end
    end
  endtask

  task automatic test_branch();
    int n;
    assert_rst(); release_rst();
    lat = 3; n = 0;
    while (mq.size() < 2 && n < 20) begin step(0, 0, 0, 1); n++; end
    tests++;
    if (mq.size() != 2) begin fails++; $display("FAIL branch_inflight got=%0d exp=2", mq.size()); end
    step(0, 1, 32'h100, 1);
    pop_log.delete(); n = 0;
    while (pop_log.size() < 2 && n < 30) begin step(0, 0, 0, 1); n++; end
    tests++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
      fails++; $display("FAIL branch_target got=%0d pops exp=100,104", pop_log.size());
    end
  endtask

  task automatic test_align();
    assert_rst(); release_rst();
    lat = 1;
    step(0, 1, 32'h0000_0203, 1);
    acc_log.delete();
    step(0, 0, 0, 1);
    tests++;
    if (acc_log.size() != 1 || acc_log[0] !== 32'h200) begin fails++; $display("FAIL align_addr got=%0d reqs exp=1 at 00000200", acc_log.size()); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 1);
    acc_log.delete();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    tests++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addr got=%0d reqs exp=fffffffc,00000000", acc_log.size());
    end
  endtask

  task automatic test_branch_stall_rsp();
    int n;
    assert_rst(); release_rst();
    lat = 1; n = 0;
    while (!(mq.size() > 0 && mq[0].due <= cyc && fq.size() > 0) && n < 20) begin step(1, 0, 0, 1); n++; end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL bsr_setup got=timeout exp=rsp with queue"); end
    step(1, 1, 32'h40, 1);
    tests++;
    if (inst_valid !== 1'b0) begin fails++; $display("FAIL bsr_flush got=%b exp=0", inst_valid); end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
  endtask

  task automatic test_reset_midop();
    int n;
    lat = 4; n = 0;
    while (!(mq.size() + fq.size() == FQ_DEPTH && fq.size() > 0) && n < 30) begin step(1, 0, 0, 1); n++; end
    assert_rst();
    tests++;
    if ({imem_req_valid, inst_valid, inst, inst_pc} !== 66'h0) begin fails++; $display("FAIL midrst_outputs got=%b%b %h %h exp=0", imem_req_valid, inst_valid, inst, inst_pc); end
    release_rst();
    step(0, 0, 0, 1);
    tests++;
    if (acc_log.size() != 1 || acc_log[0] !== RESET_PC) begin fails++; $display("FAIL midrst_restart got=%0d reqs exp=1 at %h", acc_log.size(), RESET_PC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    rst = 1; stall = 0; branch_taken = 0; new_pc = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; efpc = RESET_PC;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_align();
    test_branch_stall_rsp();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
